// File: rtl/uvmt_cvmcu_probe_sampler.sv
// Multi-channel probe sampler: detects per-channel value changes, timestamps them,
// and drains the resulting records through a first-word fall-through FIFO.
module uvmt_cvmcu_probe_sampler #(
   parameter  int unsigned NUM_CH = 4,
   parameter  int unsigned WIDTH  = 32,
   parameter  int unsigned DEPTH  = 8,
   parameter  int unsigned TS_W   = 16,
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         en_i,
   input  logic [NUM_CH*WIDTH-1:0]   probe_i,
   input  logic                      clr_i,
   output logic                      rec_valid_o,
   input  logic                      rec_ready_i,
   output logic [CH_W-1:0]           rec_ch_o,
   output logic [WIDTH-1:0]          rec_data_o,
   output logic [TS_W-1:0]           rec_ts_o,
   output logic [LVL_W-1:0]          level_o,
   output logic [NUM_CH-1:0]         drop_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [CH_W-1:0]  ch;
      logic [WIDTH-1:0] data;
      logic [TS_W-1:0]  ts;
   } rec_t;

   logic                           primed_q;
   logic [TS_W-1:0]                ts_q, ts_d;
   logic [NUM_CH-1:0][WIDTH-1:0]   probe_v;
   logic [NUM_CH-1:0][WIDTH-1:0]   prev_q;
   logic [NUM_CH-1:0][WIDTH-1:0]   pend_val_q, pend_val_d;
   logic [NUM_CH-1:0][TS_W-1:0]    pend_ts_q, pend_ts_d;
   logic [NUM_CH-1:0]              pending_q, pending_d;
   logic [NUM_CH-1:0]              drop_q, drop_d;
   logic [NUM_CH-1:0]              chg;

   rec_t                           mem_q [DEPTH];
   rec_t                           head_q, head_d, push_rec;
   logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
   logic [LVL_W-1:0]               level_q, level_d;
   logic                           valid_q, valid_d;

   logic                           pop, push, can_accept, gnt_any;
   logic [CH_W-1:0]                gnt_ch;

   assign probe_v = probe_i;

   // Change detection and lowest-index-first arbitration
   always_comb begin
      chg     = '0;
      gnt_any = 1'b0;
      gnt_ch  = '0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         chg[k] = primed_q && en_i[k] && (probe_v[k] != prev_q[k]);
      end
      for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
         if (pending_q[k]) begin
            gnt_any = 1'b1;
            gnt_ch  = CH_W'(k);
         end
      end
   end

   assign pop        = valid_q && rec_ready_i;
   assign can_accept = (level_q < LVL_W'(DEPTH)) || pop;
   assign push       = gnt_any && can_accept;
   assign rd_nxt     = rd_ptr_q + PTR_W'(1);

   always_comb begin
      push_rec      = '0;
      push_rec.ch   = gnt_ch;
      push_rec.data = pend_val_q[gnt_ch];
      push_rec.ts   = pend_ts_q[gnt_ch];
   end

   // Next-state: pending/coalesce bookkeeping, timestamp and FIFO pointers
   always_comb begin
      pending_d  = pending_q;
      pend_val_d = pend_val_q;
      pend_ts_d  = pend_ts_q;
      drop_d     = clr_i ? '0 : drop_q;
      ts_d       = clr_i ? '0 : ts_q + TS_W'(1);
      for (int k = 0; k < int'(NUM_CH); k++) begin
         if (push && (gnt_ch == CH_W'(k))) begin
            pending_d[k] = 1'b0;
         end else if (chg[k] && pending_q[k]) begin
            drop_d[k] = 1'b1;
         end
         if (chg[k]) begin
            pending_d[k]  = 1'b1;
            pend_val_d[k] = probe_v[k];
            pend_ts_d[k]  = ts_q;
         end
      end

      level_d  = level_q;
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_nxt : rd_ptr_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      valid_d = (level_d != '0);

      // Head register keeps the fall-through record ready without a read mux on the outputs
      head_d = head_q;
      if (push && ((level_q == '0) || (pop && (level_q == LVL_W'(1))))) begin
         head_d = push_rec;
      end else if (pop) begin
         head_d = mem_q[rd_nxt];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         primed_q   <= 1'b0;
         ts_q       <= '0;
         prev_q     <= '0;
         pend_val_q <= '0;
         pend_ts_q  <= '0;
         pending_q  <= '0;
         drop_q     <= '0;
         head_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         valid_q    <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         primed_q   <= 1'b1;
         ts_q       <= ts_d;
         prev_q     <= probe_v;
         pend_val_q <= pend_val_d;
         pend_ts_q  <= pend_ts_d;
         pending_q  <= pending_d;
         drop_q     <= drop_d;
         head_q     <= head_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         valid_q    <= valid_d;
         if (push) begin
            mem_q[wr_ptr_q] <= push_rec;
         end
      end
   end

   assign rec_valid_o = valid_q;
   assign rec_ch_o    = head_q.ch;
   assign rec_data_o  = head_q.data;
   assign rec_ts_o    = head_q.ts;
   assign level_o     = level_q;
   assign drop_o      = drop_q;

endmodule

// File: tb/tb_uvmt_cvmcu_probe_sampler.sv
// Directed bench for uvmt_cvmcu_probe_sampler: vector table for the basic flows,
// hand-written sequences for backpressure, coalescing, enable, reset and timestamp wrap.
module tb_uvmt_cvmcu_probe_sampler;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   en;
   logic [127:0] probe;
   logic         clr;
   logic         ready;
   logic         rec_valid;
   logic [1:0]   rec_ch;
   logic [31:0]  rec_data;
   logic [15:0]  rec_ts;
   logic [3:0]   level;
   logic [3:0]   drop;

   // Small instance used for the timestamp wrap check
   logic [1:0]   en2;
   logic [15:0]  probe2;
   logic         rec_valid2;
   logic [0:0]   rec_ch2;
   logic [7:0]   rec_data2;
   logic [3:0]   rec_ts2;
   logic [1:0]   level2;
   logic [1:0]   drop2;

   int checks   = 0;
   int failures = 0;
   int ecount   = 0;

   always #5 clk = ~clk;

   uvmt_cvmcu_probe_sampler dut (
      .clk(clk), .reset(reset), .en_i(en), .probe_i(probe), .clr_i(clr),
      .rec_valid_o(rec_valid), .rec_ready_i(ready), .rec_ch_o(rec_ch),
      .rec_data_o(rec_data), .rec_ts_o(rec_ts), .level_o(level), .drop_o(drop)
   );

   uvmt_cvmcu_probe_sampler #(.NUM_CH(2), .WIDTH(8), .DEPTH(2), .TS_W(4)) dut2 (
      .clk(clk), .reset(reset), .en_i(en2), .probe_i(probe2), .clr_i(1'b0),
      .rec_valid_o(rec_valid2), .rec_ready_i(1'b1), .rec_ch_o(rec_ch2),
      .rec_data_o(rec_data2), .rec_ts_o(rec_ts2), .level_o(level2), .drop_o(drop2)
   );

   typedef struct {
      logic [127:0] prb;
      logic         exp_valid;
      logic [1:0]   exp_ch;
      logic [31:0]  exp_data;
      logic [15:0]  exp_ts;
      logic [3:0]   exp_level;
   } vec_t;

   typedef struct {
      int          ch;
      logic [31:0] data;
      int          ts;
   } rec_t;

   vec_t vecs [8];
   rec_t exp_q [$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // One clock; ecount mirrors the expected timestamp of the next edge
   task automatic step();
      @(posedge clk);
      #1;
      if (clr) ecount = 0;
      else     ecount++;
   endtask

   task automatic set_ch(input int k, input logic [31:0] v);
      probe[k*32 +: 32] = v;
   endtask

   task automatic push_exp(input int k, input logic [31:0] v);
      rec_t r;
      r.ch = k; r.data = v; r.ts = ecount;
      exp_q.push_back(r);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!rec_valid && n < 20) begin
         step();
         n++;
      end
      if (!rec_valid) check("wait_valid_timeout", 64'(rec_valid), 64'd1);
   endtask

   task automatic drain(input int n, input string tag);
      rec_t r;
      for (int j = 0; j < n; j++) begin
         wait_valid();
         r = exp_q.pop_front();
         check({tag, "_ch"},   64'(rec_ch),   64'(r.ch[1:0]));
         check({tag, "_data"}, 64'(rec_data), 64'(r.data));
         check({tag, "_ts"},   64'(rec_ts),   64'(r.ts[15:0]));
         step();
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, 64'(rec_valid), 64'd0);
      check({tag, "_level"}, 64'(level),     64'd0);
      check({tag, "_drop"},  64'(drop),      64'd0);
      check({tag, "_ch"},    64'(rec_ch),    64'd0);
      check({tag, "_data"},  64'(rec_data),  64'd0);
      check({tag, "_ts"},    64'(rec_ts),    64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] p1;
      logic [127:0] p2;
      int chs [3];
      p1 = 128'h00000000_000000A5_00000000_00000000;
      p2 = 128'h00000033_000000A5_00000022_00000011;
      chs[0] = 0; chs[1] = 2; chs[2] = 3;
      vecs[0] = '{p1, 1'b0, 2'd0, 32'h00, 16'd0,  4'd0};
      vecs[1] = '{p1, 1'b1, 2'd2, 32'hA5, 16'd10, 4'd1};
      vecs[2] = '{p1, 1'b0, 2'd0, 32'h00, 16'd0,  4'd0};
      vecs[3] = '{p2, 1'b0, 2'd0, 32'h00, 16'd0,  4'd0};
      vecs[4] = '{p2, 1'b1, 2'd0, 32'h11, 16'd13, 4'd1};
      vecs[5] = '{p2, 1'b1, 2'd1, 32'h22, 16'd13, 4'd1};
      vecs[6] = '{p2, 1'b1, 2'd3, 32'h33, 16'd13, 4'd1};
      vecs[7] = '{p2, 1'b0, 2'd0, 32'h00, 16'd0,  4'd0};

      reset = 1'b1; en = 4'hF; probe = '0; clr = 1'b0; ready = 1'b1;
      en2 = 2'b11; probe2 = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      reset = 1'b0;
      ecount = 0;

      // Idle through the priming edge up to edge 10
      repeat (10) step();
      check("idle_valid", 64'(rec_valid), 64'd0);

      // Single change then three simultaneous changes
      for (int i = 0; i < 8; i++) begin
         probe = vecs[i].prb;
         step();
         check($sformatf("vec%0d_valid", i), 64'(rec_valid), 64'(vecs[i].exp_valid));
         check($sformatf("vec%0d_level", i), 64'(level),     64'(vecs[i].exp_level));
         check($sformatf("vec%0d_drop", i),  64'(drop),      64'd0);
         if (vecs[i].exp_valid) begin
            check($sformatf("vec%0d_ch", i),   64'(rec_ch),   64'(vecs[i].exp_ch));
            check($sformatf("vec%0d_data", i), 64'(rec_data), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d_ts", i),   64'(rec_ts),   64'(vecs[i].exp_ts));
         end
      end

      // Backpressure: 9 changes into an 8-deep FIFO, the 9th waits pending
      ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         set_ch(i % 4, 32'h100 + 32'(i));
         push_exp(i % 4, 32'h100 + 32'(i));
         step();
      end
      repeat (2) step();
      check("full_level", 64'(level), 64'd8);
      check("full_valid", 64'(rec_valid), 64'd1);
      ready = 1'b1;
      drain(9, "bp");
      check("bp_level_after", 64'(level), 64'd0);
      check("bp_drop_after",  64'(drop),  64'd0);

      // Coalesce on ch1 while the FIFO is full
      ready = 1'b0;
      en = 4'b1101; set_ch(1, 32'h1); step();
      en = 4'hF; step();
      for (int i = 0; i < 8; i++) begin
         set_ch(chs[i % 3], 32'h200 + 32'(i));
         push_exp(chs[i % 3], 32'h200 + 32'(i));
         step();
      end
      repeat (2) step();
      check("co_level", 64'(level), 64'd8);
      set_ch(1, 32'h2); step();
      check("co_drop_first", 64'(drop), 64'd0);
      set_ch(1, 32'h3); push_exp(1, 32'h3); step();
      check("co_drop", 64'(drop), 64'b0010);
      ready = 1'b1;
      drain(9, "co");
      check("co_drop_held", 64'(drop), 64'b0010);
      clr = 1'b1; step(); clr = 1'b0;
      check("co_drop_clr", 64'(drop), 64'd0);

      // Pending change survives en falling; disabled toggles and en rising make nothing
      set_ch(3, 32'h400); push_exp(3, 32'h400); step();
      en = 4'b0111;
      step();
      drain(1, "enfall");
      for (int i = 0; i < 4; i++) begin
         set_ch(3, 32'h300 + 32'(i));
         step();
         check("dis_valid", 64'(rec_valid), 64'd0);
      end
      en = 4'hF;
      for (int i = 0; i < 4; i++) begin
         step();
         check("enrise_valid", 64'(rec_valid), 64'd0);
      end
      check("enrise_level", 64'(level), 64'd0);

      // Mid-operation reset with level 5 and two channels pending
      ready = 1'b0;
      for (int k = 0; k < 4; k++) set_ch(k, 32'h500 + 32'(k));
      step();
      for (int i = 0; i < 3; i++) begin
         set_ch(0, 32'h510 + 32'(i));
         step();
      end
      repeat (2) step();
      check("pre_rst_level", 64'(level), 64'd5);
      check("pre_rst_drop",  64'(drop),  64'd0);
      #2;
      reset = 1'b1;
      #1;
      check_reset_state("async_rst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      ecount = 0;
      ready = 1'b1;
      for (int k = 0; k < 4; k++) set_ch(k, 32'h600 + 32'(k));
      for (int i = 0; i < 4; i++) begin
         step();
         check("prime_valid", 64'(rec_valid), 64'd0);
      end
      check("prime_level", 64'(level), 64'd0);

      // 4-bit timestamp wraps: change at edge 17 carries ts 1
      while (ecount < 17) step();
      probe2[7:0] = 8'h5A;
      step();
      step();
      check("wrap_valid", 64'(rec_valid2), 64'd1);
      check("wrap_ch",    64'(rec_ch2),    64'd0);
      check("wrap_data",  64'(rec_data2),  64'h5A);
      check("wrap_ts",    64'(rec_ts2),    64'd1);
      check("wrap_level", 64'(level2),     64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
